// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush/redirect controller.
// Stall vectors use the same bit order as the pipeline: PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
package pipeline_ctrl_pkg;

  localparam int unsigned NUM_STAGES  = 5;

  localparam int unsigned STALL_PC    = 0;
  localparam int unsigned STALL_IFID  = 1;
  localparam int unsigned STALL_IDEX  = 2;
  localparam int unsigned STALL_EXMEM = 3;
  localparam int unsigned STALL_MEMWB = 4;

  localparam logic [NUM_STAGES-1:0] STALL_NONE  = 5'b00000;
  localparam logic [NUM_STAGES-1:0] STALL_ALL   = 5'b11111;
  localparam logic [NUM_STAGES-1:0] STALL_DIV   = 5'b00111;
  localparam logic [NUM_STAGES-1:0] STALL_LOAD  = 5'b00011;
  localparam logic [NUM_STAGES-1:0] STALL_FETCH = 5'b00001;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // A held register feeding a moving one must inject a bubble into the moving one.
  function automatic logic [NUM_STAGES-1:0] bubble_from_stall(input logic [NUM_STAGES-1:0] stall);
    logic [NUM_STAGES-1:0] bubble;
    bubble = '0;
    for (int k = 0; k < NUM_STAGES - 1; k++) begin
      bubble[k+1] = stall[k] & ~stall[k+1];
    end
    return bubble;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination is read by the instruction in ID.
module pipeline_ctrl_hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] id_reg1_addr_i,
  input  logic       id_reg1_read_i,
  input  logic [4:0] id_reg2_addr_i,
  input  logic       id_reg2_read_i,
  input  logic       ex_rmem_i,
  input  logic       ex_wreg_i,
  input  logic [4:0] ex_wd_i,
  output logic       load_use_o
);

  logic w_ex_load_dst;
  logic w_src1_hit;
  logic w_src2_hit;

  // $zero is never a real producer, so it can never create a hazard.
  assign w_ex_load_dst = ex_rmem_i & ex_wreg_i & (ex_wd_i != 5'd0);
  assign w_src1_hit    = id_reg1_read_i & (id_reg1_addr_i == ex_wd_i);
  assign w_src2_hit    = id_reg2_read_i & (id_reg2_addr_i == ex_wd_i);
  assign load_use_o    = w_ex_load_dst & (w_src1_hit | w_src2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush/redirect controller for the 5-stage core: load-use, divider,
// cache-miss stalls and exception/ERET flush with a held PC redirect.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned DIV_LATENCY = 34,
  parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            id_reg1_addr_i,
  input  logic                  id_reg1_read_i,
  input  logic [4:0]            id_reg2_addr_i,
  input  logic                  id_reg2_read_i,
  input  logic                  ex_rmem_i,
  input  logic                  ex_wreg_i,
  input  logic [4:0]            ex_wd_i,
  input  logic                  ex_div_start_i,
  input  logic                  mem_except_i,
  input  logic                  mem_eret_i,
  input  logic [31:0]           cp0_epc_i,
  input  logic                  icache_stall_i,
  input  logic                  dcache_stall_i,
  input  logic                  pc_ack_i,
  output logic [NUM_STAGES-1:0] stall_o,
  output logic [NUM_STAGES-1:0] bubble_o,
  output logic                  flush_o,
  output logic [31:0]           new_pc_o,
  output logic                  new_pc_valid_o,
  output logic                  div_busy_o
);

  localparam int unsigned       CNT_W    = $clog2(DIV_LATENCY);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DIV_LATENCY - 2);

  logic             w_flush;
  logic             w_load_use;
  logic             w_pc_hold;
  div_state_t       r_div_state;
  div_state_t       w_div_state_next;
  logic [CNT_W-1:0] r_div_cnt;
  logic [CNT_W-1:0] w_div_cnt_next;
  logic [31:0]      r_new_pc;
  logic             r_new_pc_valid;

  pipeline_ctrl_hazard_detect u_hazard_detect (
    .id_reg1_addr_i (id_reg1_addr_i),
    .id_reg1_read_i (id_reg1_read_i),
    .id_reg2_addr_i (id_reg2_addr_i),
    .id_reg2_read_i (id_reg2_read_i),
    .ex_rmem_i      (ex_rmem_i),
    .ex_wreg_i      (ex_wreg_i),
    .ex_wd_i        (ex_wd_i),
    .load_use_o     (w_load_use)
  );

  assign w_flush   = mem_except_i | mem_eret_i;
  assign w_pc_hold = r_new_pc_valid & ~pc_ack_i;

  // Divider FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_state <= IDLE;
      r_div_cnt   <= '0;
    end else begin
      r_div_state <= w_div_state_next;
      r_div_cnt   <= w_div_cnt_next;
    end
  end

  // Divider FSM: next state.
  always_comb begin
    w_div_state_next = r_div_state;
    w_div_cnt_next   = r_div_cnt;
    if (w_flush) begin
      w_div_state_next = IDLE;
    end else begin
      unique case (r_div_state)
        IDLE: begin
          if (ex_div_start_i) begin
            w_div_state_next = BUSY;
            w_div_cnt_next   = CNT_LOAD;
          end
        end
        BUSY: begin
          // A data-cache miss freezes the whole pipe, divider included.
          if (!dcache_stall_i) begin
            if (r_div_cnt == '0) begin
              w_div_state_next = DONE;
            end else begin
              w_div_cnt_next = r_div_cnt - CNT_W'(1);
            end
          end
        end
        DONE: begin
          // The start seen here belongs to the divide that just finished.
          w_div_state_next = IDLE;
        end
        default: w_div_state_next = IDLE;
      endcase
    end
  end

  // Stall/bubble/flush outputs.
  always_comb begin
    stall_o    = STALL_NONE;
    bubble_o   = STALL_NONE;
    flush_o    = 1'b0;
    div_busy_o = (r_div_state != IDLE);
    if (w_flush) begin
      flush_o  = 1'b1;
      bubble_o = STALL_ALL;
    end else begin
      if (dcache_stall_i) begin
        stall_o = STALL_ALL;
      end else if (r_div_state == BUSY) begin
        stall_o = STALL_DIV;
      end else if (w_load_use) begin
        stall_o = STALL_LOAD;
      end else if (icache_stall_i) begin
        stall_o = STALL_FETCH;
      end
      if (w_pc_hold) begin
        stall_o[STALL_PC] = 1'b1;
      end
      bubble_o = bubble_from_stall(stall_o);
    end
  end

  // Redirect target is held until the PC register acknowledges it; a later flush overwrites.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_new_pc       <= '0;
      r_new_pc_valid <= 1'b0;
    end else if (w_flush) begin
      r_new_pc       <= mem_eret_i ? cp0_epc_i : EXC_VECTOR;
      r_new_pc_valid <= 1'b1;
    end else if (r_new_pc_valid && pc_ack_i) begin
      r_new_pc       <= '0;
      r_new_pc_valid <= 1'b0;
    end
  end

  assign new_pc_o       = r_new_pc;
  assign new_pc_valid_o = r_new_pc_valid;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hazards, divider sequencing, flush and redirect handshake.
module tb_pipeline_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_reg1_addr_i;
  logic        id_reg1_read_i;
  logic [4:0]  id_reg2_addr_i;
  logic        id_reg2_read_i;
  logic        ex_rmem_i;
  logic        ex_wreg_i;
  logic [4:0]  ex_wd_i;
  logic        ex_div_start_i;
  logic        mem_except_i;
  logic        mem_eret_i;
  logic [31:0] cp0_epc_i;
  logic        icache_stall_i;
  logic        dcache_stall_i;
  logic        pc_ack_i;
  logic [4:0]  stall_o;
  logic [4:0]  bubble_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        new_pc_valid_o;
  logic        div_busy_o;

  int n_checks;
  int n_fails;

  pipeline_ctrl #(
    .DIV_LATENCY (34),
    .EXC_VECTOR  (32'hBFC00380)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_reg1_addr_i (id_reg1_addr_i),
    .id_reg1_read_i (id_reg1_read_i),
    .id_reg2_addr_i (id_reg2_addr_i),
    .id_reg2_read_i (id_reg2_read_i),
    .ex_rmem_i      (ex_rmem_i),
    .ex_wreg_i      (ex_wreg_i),
    .ex_wd_i        (ex_wd_i),
    .ex_div_start_i (ex_div_start_i),
    .mem_except_i   (mem_except_i),
    .mem_eret_i     (mem_eret_i),
    .cp0_epc_i      (cp0_epc_i),
    .icache_stall_i (icache_stall_i),
    .dcache_stall_i (dcache_stall_i),
    .pc_ack_i       (pc_ack_i),
    .stall_o        (stall_o),
    .bubble_o       (bubble_o),
    .flush_o        (flush_o),
    .new_pc_o       (new_pc_o),
    .new_pc_valid_o (new_pc_valid_o),
    .div_busy_o     (div_busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    id_reg1_addr_i = '0;
    id_reg1_read_i = 1'b0;
    id_reg2_addr_i = '0;
    id_reg2_read_i = 1'b0;
    ex_rmem_i      = 1'b0;
    ex_wreg_i      = 1'b0;
    ex_wd_i        = '0;
    ex_div_start_i = 1'b0;
    mem_except_i   = 1'b0;
    mem_eret_i     = 1'b0;
    cp0_epc_i      = '0;
    icache_stall_i = 1'b0;
    dcache_stall_i = 1'b0;
    pc_ack_i       = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    sample();
    check("rst_stall", 32'(stall_o), 32'h0);
    check("rst_bubble", 32'(bubble_o), 32'h0);
    check("rst_flush", 32'(flush_o), 32'h0);
    check("rst_new_pc", new_pc_o, 32'h0);
    check("rst_pc_valid", 32'(new_pc_valid_o), 32'h0);
    check("rst_div_busy", 32'(div_busy_o), 32'h0);

    // Load-use on source 1.
    step();
    ex_rmem_i = 1'b1; ex_wreg_i = 1'b1; ex_wd_i = 5'd8;
    id_reg1_read_i = 1'b1; id_reg1_addr_i = 5'd8;
    sample();
    check("lu1_stall", 32'(stall_o), 32'h03);
    check("lu1_bubble", 32'(bubble_o), 32'h04);
    // Load-use beats icache stall.
    step();
    icache_stall_i = 1'b1;
    sample();
    check("lu_icache_stall", 32'(stall_o), 32'h03);
    // Source 2 match.
    step();
    icache_stall_i = 1'b0; id_reg1_read_i = 1'b0;
    id_reg2_read_i = 1'b1; id_reg2_addr_i = 5'd8;
    sample();
    check("lu2_stall", 32'(stall_o), 32'h03);
    // $zero destination never hazards.
    step();
    ex_wd_i = 5'd0; id_reg2_addr_i = 5'd0;
    sample();
    check("lu_zero_stall", 32'(stall_o), 32'h00);
    check("lu_zero_bubble", 32'(bubble_o), 32'h00);
    // Fetch stall alone.
    step();
    clear_inputs();
    icache_stall_i = 1'b1;
    sample();
    check("ic_stall", 32'(stall_o), 32'h01);
    check("ic_bubble", 32'(bubble_o), 32'h02);

    // Plain divide: 33 stalled BUSY cycles, then DONE.
    step();
    clear_inputs();
    ex_div_start_i = 1'b1;
    sample();
    check("div_start_stall", 32'(stall_o), 32'h00);
    step();
    ex_div_start_i = 1'b0;
    for (int i = 0; i < 33; i++) begin
      sample();
      check("div_busy_stall", 32'(stall_o), 32'h07);
      check("div_busy_bubble", 32'(bubble_o), 32'h08);
      check("div_busy_flag", 32'(div_busy_o), 32'h1);
      step();
    end
    ex_div_start_i = 1'b1;
    sample();
    check("div_done_stall", 32'(stall_o), 32'h00);
    check("div_done_busy", 32'(div_busy_o), 32'h1);
    step();
    ex_div_start_i = 1'b0;
    sample();
    check("div_idle_busy", 32'(div_busy_o), 32'h0);
    check("div_idle_stall", 32'(stall_o), 32'h00);

    // Divide with a 5-cycle dcache miss: BUSY span extends to 38 cycles.
    step();
    ex_div_start_i = 1'b1;
    step();
    ex_div_start_i = 1'b0;
    for (int i = 0; i < 38; i++) begin
      dcache_stall_i = (i >= 5 && i < 10);
      sample();
      check("divdc_stall", 32'(stall_o), (i >= 5 && i < 10) ? 32'h1F : 32'h07);
      step();
    end
    dcache_stall_i = 1'b0;
    sample();
    check("divdc_done_stall", 32'(stall_o), 32'h00);
    check("divdc_done_busy", 32'(div_busy_o), 32'h1);
    step();
    sample();
    check("divdc_idle_busy", 32'(div_busy_o), 32'h0);

    // Exception on the 10th BUSY cycle.
    step();
    ex_div_start_i = 1'b1;
    step();
    ex_div_start_i = 1'b0;
    for (int i = 0; i < 9; i++) step();
    mem_except_i = 1'b1;
    sample();
    check("exc_flush", 32'(flush_o), 32'h1);
    check("exc_bubble", 32'(bubble_o), 32'h1F);
    check("exc_stall", 32'(stall_o), 32'h00);
    step();
    mem_except_i = 1'b0;
    sample();
    check("exc_div_idle", 32'(div_busy_o), 32'h0);
    check("exc_new_pc", new_pc_o, 32'hBFC00380);
    check("exc_pc_valid", 32'(new_pc_valid_o), 32'h1);
    check("exc_hold_stall", 32'(stall_o), 32'h01);
    check("exc_hold_bubble", 32'(bubble_o), 32'h02);
    step();
    pc_ack_i = 1'b1;
    sample();
    check("exc_ack_stall", 32'(stall_o), 32'h00);
    step();
    pc_ack_i = 1'b0;
    sample();
    check("exc_cleared", 32'(new_pc_valid_o), 32'h0);

    // ERET with a 3-cycle acknowledge delay.
    step();
    cp0_epc_i = 32'h80001234; mem_eret_i = 1'b1;
    sample();
    check("eret_flush", 32'(flush_o), 32'h1);
    step();
    mem_eret_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("eret_valid", 32'(new_pc_valid_o), 32'h1);
      check("eret_pc", new_pc_o, 32'h80001234);
      check("eret_pc_stall", 32'(stall_o[0]), 32'h1);
      step();
    end
    pc_ack_i = 1'b1;
    sample();
    check("eret_valid_ack", 32'(new_pc_valid_o), 32'h1);
    check("eret_ack_stall", 32'(stall_o), 32'h00);
    step();
    pc_ack_i = 1'b0;
    sample();
    check("eret_cleared", 32'(new_pc_valid_o), 32'h0);

    // Both flush sources: ERET target wins; a later exception overwrites while pending.
    step();
    cp0_epc_i = 32'h8000ABCC; mem_eret_i = 1'b1; mem_except_i = 1'b1;
    step();
    mem_eret_i = 1'b0; mem_except_i = 1'b0;
    sample();
    check("both_pc", new_pc_o, 32'h8000ABCC);
    step();
    mem_except_i = 1'b1;
    step();
    mem_except_i = 1'b0;
    sample();
    check("ovr_pc", new_pc_o, 32'hBFC00380);
    check("ovr_valid", 32'(new_pc_valid_o), 32'h1);

    // Reset in the middle of a divide with a redirect still pending.
    ex_div_start_i = 1'b1;
    step();
    ex_div_start_i = 1'b0;
    step();
    step();
    sample();
    check("prerst_busy", 32'(div_busy_o), 32'h1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sample();
    check("midrst_busy", 32'(div_busy_o), 32'h0);
    check("midrst_stall", 32'(stall_o), 32'h00);
    check("midrst_bubble", 32'(bubble_o), 32'h00);
    check("midrst_valid", 32'(new_pc_valid_o), 32'h0);
    check("midrst_pc", new_pc_o, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush/redirect controller for the 5-stage MIPS core.
- Drives the stall and flush inputs of every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Detects load-use hazards, sequences the multi-cycle divider stall, stalls on cache misses, and handles exception/ERET flush and PC redirect with a hold-until-accepted handshake.

Parameters:
- DIV_LATENCY, 34: cycles a DIV/DIVU occupies EX, counting from ex_div_start_i through the last busy cycle.
- EXC_VECTOR, 32'hBFC00380: redirect target for all exceptions other than ERET.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- id_reg1_addr_i  in  5  ID source 1 address
- id_reg1_read_i  in  1  ID reads source 1
- id_reg2_addr_i  in  5  ID source 2 address
- id_reg2_read_i  in  1  ID reads source 2
- ex_rmem_i  in  1  EX holds a load
- ex_wreg_i  in  1  EX writes the register file
- ex_wd_i  in  5  EX destination register
- ex_div_start_i  in  1  DIV/DIVU in EX, first cycle
- mem_except_i  in  1  MEM stage commits an exception
- mem_eret_i  in  1  MEM stage commits ERET
- cp0_epc_i  in  32  EPC value
- icache_stall_i  in  1  instruction fetch waiting
- dcache_stall_i  in  1  data access waiting
- pc_ack_i  in  1  PC register accepted the redirect
- stall_o  out  5  hold bits; bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB
- bubble_o  out  5  per-register flush; same bit order as stall_o
- flush_o  out  1  flush all pipeline registers
- new_pc_o  out  32  redirect target
- new_pc_valid_o  out  1  redirect pending
- div_busy_o  out  1  divider FSM not IDLE

Behaviour:
- Reset values:
  - stall_o=0, bubble_o=0, flush_o=0.
  - new_pc_o=0, new_pc_valid_o=0.
  - div FSM=IDLE, div counter=0, redirect register cleared.
- Bubble rule: whenever stall_o[k]=1 and stall_o[k+1]=0 (k<4), bubble_o[k+1]=1 in the same cycle. All other bubble_o bits are 0 unless flush_o=1.
- Priority, evaluated combinationally every cycle, highest first:
  1. Flush: mem_except_i|mem_eret_i.
     - flush_o=1, bubble_o=5'b11111, stall_o=0.
     - Forces the div FSM to IDLE on the next edge.
  2. dcache_stall_i: stall_o=5'b11111.
  3. Div BUSY: stall_o=5'b00111.
  4. Load-use: ex_rmem_i & ex_wreg_i & ex_wd_i!=0 & ((id_reg1_read_i & id_reg1_addr_i==ex_wd_i) | (id_reg2_read_i & id_reg2_addr_i==ex_wd_i)).
     - stall_o=5'b00011, so ID/EX receives a bubble.
  5. icache_stall_i: stall_o=5'b00001, so IF/ID receives a bubble.
  6. Otherwise all zero.
- Div FSM (IDLE, BUSY, DONE):
  - IDLE -> BUSY when ex_div_start_i & ~flush_o; counter loads DIV_LATENCY-2.
  - In BUSY, the counter decrements each cycle unless dcache_stall_i=1 (then it holds). BUSY -> DONE when the counter is 0 and it is decremented.
  - DONE lasts 1 cycle with no div stall (EX result advances); then DONE -> IDLE.
  - ex_div_start_i seen in DONE is ignored: the same instruction is still present.
  - Stall span per DIV: DIV_LATENCY-1 cycles, plus cycles added by dcache_stall_i.
  - div_busy_o = (state!=IDLE).
- Redirect register:
  - On a flush cycle, next edge: new_pc_valid_o<=1; new_pc_o<=cp0_epc_i if mem_eret_i else EXC_VECTOR. ERET wins if both are set.
  - Cleared on the edge where new_pc_valid_o & pc_ack_i.
  - A new flush while the redirect is pending overwrites the target; valid stays 1.
  - While valid & ~pc_ack_i, stall_o[0] is forced to 1 and the rest of stall_o follows the priority rules.
- rst mid-divide or mid-redirect: everything returns to reset values on the next edge.
- Widths: register addresses are compared at 5 bits; $zero never hazards.

Decomposition:
- Shared package:
  - stall-vector bit index constants (STALL_PC..STALL_MEMWB)
  - div_state_t enum {IDLE, BUSY, DONE}
  - EXC_VECTOR default
- One sub-module, hazard_detect: the combinational load-use compare. Div FSM and redirect logic stay in the top module.

Test Plan:
- Load-use: ex_rmem_i=1, ex_wreg_i=1, ex_wd_i=8, id_reg1_read_i=1, id_reg1_addr_i=8 -> stall_o=5'b00011, bubble_o=5'b00100 for exactly that cycle; with ex_wd_i=0 -> all zero.
- DIV with DIV_LATENCY=34: ex_div_start_i pulse -> stall_o=5'b00111 and bubble_o=5'b01000 for 33 cycles, then one DONE cycle with stall_o=0, then IDLE; div_busy_o high for 34 cycles.
- Exception mid-divide, cycle 10 of BUSY: mem_except_i=1 -> flush_o=1, bubble_o=5'b11111 that cycle; next cycle FSM IDLE, new_pc_o=32'hBFC00380, new_pc_valid_o=1.
- ERET with cp0_epc_i=32'h80001234 and pc_ack_i=0 for 3 cycles -> new_pc_valid_o held 4 cycles with stall_o[0]=1; cleared the edge after pc_ack_i=1.
- dcache_stall_i=1 for 5 cycles during BUSY -> stall_o=5'b11111 and the divider counter frozen; total stall is extended by exactly 5 cycles.
- Simultaneous icache_stall_i and load-use -> stall_o=5'b00011 (load-use wins); rst asserted in BUSY -> all outputs 0 next cycle.
